imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Controller for the synchronous instruction memory, which has one registered read port (1-cycle latency) and one write strobe.
- It shares that memory between two requesters: the CPU fetch stage (read-only) and the program loader/debug port (read/write).
- It holds the CPU in a boot state until the loader signals that the image is written.
- It sits between the PC/fetch logic and the instruction memory instance.

Parameters:
- MEM_SIZE, 256, number of 32-bit words in instruction memory; word-addressed.
- ADDR_W, 32, width of all address ports.
- MAX_BURST, 4, max consecutive loader grants while a fetch is pending (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request, level; held until f_gnt.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid (cycle after f_gnt).
- f_rdata  out  32  fetch read data.
- f_err  out  1  with f_rvalid: address out of range.
- l_req  in  1  loader request, level; held until l_gnt.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  ADDR_W  loader word address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted.
- l_rvalid  out  1  loader read data valid (cycle after a read grant).
- l_rdata  out  32  loader read data.
- l_err  out  1  with l_rvalid or with a write l_gnt: out of range.
- l_boot_done  in  1  pulse: image loaded, release CPU.
- cpu_hold  out  1  stall CPU; high in BOOT.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, registered, valid the cycle after mem_addr is presented.

Behaviour:
- Reset (async, rst_n=0):
  - State=BOOT, cpu_hold=1.
  - f_gnt, l_gnt, f_rvalid, l_rvalid, f_err, l_err, mem_we = 0.
  - mem_addr, mem_wdata, f_rdata, l_rdata = 0.
  - Burst counter = 0. Any in-flight read is discarded; no rvalid after reset.
- States:
  - BOOT: only the loader is served; f_gnt is held 0.
    - l_boot_done=1 -> RUN next cycle, cpu_hold=0 next cycle.
    - If l_boot_done and l_req occur in the same cycle, the loader request is still granted.
  - RUN: both requesters are arbitrated. l_boot_done is ignored.
  - There is no return to BOOT except by reset.
- Grants:
  - At most one grant per cycle.
  - Grant outputs are combinational from the request and the state, so issue is same-cycle.
  - mem_addr, mem_we and mem_wdata are driven combinationally from the winner in the same cycle.
  - If there is no winner: mem_we=0 and mem_addr holds its last value.
- Arbitration in RUN:
  - Loader has priority.
  - Exception: if f_req=1 and burst counter == MAX_BURST, fetch wins.
  - Burst counter:
    - +1 on each loader grant while f_req=1, saturating at MAX_BURST.
    - Cleared on a fetch grant, or on any cycle with f_req=0.
- Range check:
  - Address >= MEM_SIZE -> grant is still issued, but mem_we is forced 0.
  - Out-of-range read: the response cycle carries rdata=0 and err=1.
  - Out-of-range write: l_err=1 in the grant cycle.
  - In-range accesses: err=0.
- Read response:
  - The owner and range flag are registered at grant.
  - Next cycle: the owner's rvalid=1 and rdata=mem_rdata (or 0 if out of range). The other requester's rvalid stays 0.
  - Back-to-back grants give back-to-back responses (fully pipelined, 1 outstanding per cycle).
- Writes produce no rvalid. mem_we is asserted only in the grant cycle.
- A read of an address in the cycle after a write to the same address returns the new data (memory write-first is not required; the grant ordering guarantees it).

Test Plan:
- Reset mid-read: grant fetch at addr 5, assert rst_n=0 before the next edge -> f_rvalid stays 0, cpu_hold=1, state BOOT.
- BOOT gating: f_req=1 with addr 0 throughout BOOT -> f_gnt=0. Loader writes 0x20080005 to addr 0, then pulses l_boot_done -> cpu_hold falls next cycle. Fetch is then granted and f_rdata=0x20080005 the cycle after.
- Starvation bound (MAX_BURST=4): in RUN, l_req and f_req held high -> grants L,L,L,L,F,L,L,L,L,F repeating.
- Pipelining: fetch grants at addrs 1,2,3 on consecutive cycles -> f_rvalid high on 3 consecutive cycles with the contents of addrs 1,2,3 in order.
- Out of range: loader write to addr 256 -> mem_we=0 and l_err=1 in the grant cycle. Fetch read of addr 300 -> f_rvalid=1, f_rdata=0, f_err=1.
- Write-then-read: loader writes 0xDEADBEEF to addr 7, then the loader reads addr 7 next cycle -> l_rdata=0xDEADBEEF, l_err=0.

Source files
------------

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one registered-read memory port between the
// CPU fetch stage and the loader, and holds the CPU in BOOT until the image is loaded.
module imem_arbiter #(
    parameter int MEM_SIZE  = 256,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,

    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              l_err,
    input  logic              l_boot_done,

    output logic              cpu_hold,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic              dbg_state
);

    // Handshake: a requester holds req (and its address/data) until it sees gnt;
    // a transfer happens in exactly the cycles where req && gnt.

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_SIZE);
    localparam logic [3:0]        BURST_MAX = 4'(MAX_BURST);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        burst_q, burst_d;
    logic [ADDR_W-1:0] last_addr_q;
    logic              f_rv_q, l_rv_q, oor_q;

    logic              fetch_win, load_win, any_win, win_in_range;
    logic [ADDR_W-1:0] win_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && l_boot_done) begin
            state_d = RUN;
        end
    end

    assign cpu_hold  = (state_q == BOOT);
    assign dbg_state = (state_q == RUN);

    // Loader has priority unless a waiting fetch has already seen MAX_BURST loader grants.
    always_comb begin
        fetch_win = 1'b0;
        load_win  = 1'b0;
        if (state_q == RUN && f_req && (!l_req || burst_q == BURST_MAX)) begin
            fetch_win = 1'b1;
        end else if (l_req) begin
            load_win = 1'b1;
        end
        any_win      = fetch_win | load_win;
        win_addr     = fetch_win ? f_addr : l_addr;
        win_in_range = (win_addr < MEM_LIMIT);
    end

    always_comb begin
        burst_d = burst_q;
        if (!f_req || fetch_win) begin
            burst_d = 4'd0;
        end else if (load_win && burst_q != BURST_MAX) begin
            burst_d = burst_q + 4'd1;
        end
    end

    assign f_gnt     = fetch_win;
    assign l_gnt     = load_win;
    assign mem_addr  = any_win ? win_addr : last_addr_q;
    assign mem_we    = load_win && l_we && win_in_range;
    assign mem_wdata = (load_win && l_we) ? l_wdata : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q     <= 4'd0;
            last_addr_q <= '0;
            f_rv_q      <= 1'b0;
            l_rv_q      <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            burst_q <= burst_d;
            if (any_win) begin
                last_addr_q <= win_addr;
            end
            f_rv_q <= fetch_win;
            l_rv_q <= load_win && !l_we;
            oor_q  <= any_win && !win_in_range;
        end
    end

    // Out-of-range reads return zero data with err; memory output is ignored then.
    assign f_rvalid = f_rv_q;
    assign f_err    = f_rv_q && oor_q;
    assign f_rdata  = (f_rv_q && !oor_q) ? mem_rdata : 32'd0;

    assign l_rvalid = l_rv_q;
    assign l_rdata  = (l_rv_q && !oor_q) ? mem_rdata : 32'd0;
    assign l_err    = (l_rv_q && oor_q) || (load_win && l_we && !win_in_range);

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus random traffic, checked cycle by
// cycle against a transaction-level model of the arbitration and memory contents.
module tb_imem_arbiter;

    localparam int MEM_SIZE  = 256;
    localparam int ADDR_W    = 32;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              f_req = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic              f_gnt, f_rvalid, f_err;
    logic [31:0]       f_rdata;
    logic              l_req = 1'b0, l_we = 1'b0, l_boot_done = 1'b0;
    logic [ADDR_W-1:0] l_addr = '0;
    logic [31:0]       l_wdata = '0;
    logic              l_gnt, l_rvalid, l_err;
    logic [31:0]       l_rdata;
    logic              cpu_hold;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              dbg_state;

    imem_arbiter #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .l_boot_done(l_boot_done), .cpu_hold(cpu_hold),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous memory: registered read, write strobe.
    logic [31:0] tb_mem [0:MEM_SIZE-1];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr[7:0]];
    end

    // Reference model state.
    logic [31:0] ref_mem [0:MEM_SIZE-1];
    bit          m_boot;
    int          m_waited;
    bit          pend_f, pend_l, pend_err;
    logic [31:0] pend_data;
    logic [31:0] m_last_addr;
    bit          last_f, last_l;
    string       glog;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_waited = 0;
        pend_f = 1'b0;
        pend_l = 1'b0;
        pend_err = 1'b0;
        pend_data = '0;
        m_last_addr = '0;
        last_f = 1'b0;
        last_l = 1'b0;
    endtask

    // One clock: inputs are already driven; check at negedge, advance model, step to posedge+1.
    task automatic cycle();
        bit          exp_f, exp_l, ok, wr;
        logic [31:0] addr;
        @(negedge clk);
        exp_f = !m_boot && f_req && (!l_req || m_waited >= MAX_BURST);
        exp_l = l_req && !exp_f;
        addr  = exp_f ? f_addr : l_addr;
        ok    = (addr < MEM_SIZE);
        wr    = exp_l && l_we;

        if (f_gnt) glog = {glog, "F"};
        else if (l_gnt) glog = {glog, "L"};
        else glog = {glog, "-"};

        chk("f_gnt", f_gnt, exp_f);
        chk("l_gnt", l_gnt, exp_l);
        chk("mem_we", mem_we, wr && ok);
        chk("mem_addr", mem_addr, (exp_f || exp_l) ? addr : m_last_addr);
        if (wr && ok) chk("mem_wdata", mem_wdata, l_wdata);
        chk("cpu_hold", cpu_hold, m_boot);
        chk("dbg_state", dbg_state, !m_boot);
        chk("f_rvalid", f_rvalid, pend_f);
        chk("l_rvalid", l_rvalid, pend_l);
        if (pend_f) begin
            chk("f_rdata", f_rdata, pend_data);
            chk("f_err", f_err, pend_err);
        end
        if (pend_l) chk("l_rdata", l_rdata, pend_data);
        chk("l_err", l_err, (pend_l && pend_err) || (wr && !ok));

        pend_f    = exp_f;
        pend_l    = exp_l && !l_we;
        pend_err  = !ok;
        pend_data = ok ? ref_mem[addr[7:0]] : 32'd0;
        if (wr && ok) ref_mem[addr[7:0]] = l_wdata;
        if (exp_f || exp_l) m_last_addr = addr;
        if (!f_req || exp_f) m_waited = 0;
        else if (exp_l && m_waited < MAX_BURST) m_waited++;
        if (m_boot && l_boot_done) m_boot = 1'b0;
        last_f = exp_f;
        last_l = exp_l;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 32'($urandom_range(256, 300));
        return 32'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        model_reset();
        glog = "";

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_f_gnt", f_gnt, 1'b0);
        chk("rst_l_gnt", l_gnt, 1'b0);
        chk("rst_f_rvalid", f_rvalid, 1'b0);
        chk("rst_l_rvalid", l_rvalid, 1'b0);
        chk("rst_f_err", f_err, 1'b0);
        chk("rst_l_err", l_err, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_f_rdata", f_rdata, 32'd0);
        chk("rst_l_rdata", l_rdata, 32'd0);
        chk("rst_cpu_hold", cpu_hold, 1'b1);
        chk("rst_dbg_state", dbg_state, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // BOOT gating and image load
        f_req = 1'b1; f_addr = 32'd0;
        repeat (2) cycle();
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'd0; l_wdata = 32'h2008_0005;
        cycle();
        l_req = 1'b0; l_we = 1'b0; l_boot_done = 1'b1;
        cycle();
        l_boot_done = 1'b0;
        cycle();
        f_req = 1'b0;
        cycle();
        chk("boot_image", ref_mem[0], 32'h2008_0005);

        // Starvation bound with both requesters held
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'd10;
        f_req = 1'b1; f_addr = 32'd11;
        glog = "";
        repeat (10) cycle();
        chk("burst_pattern", 32'(glog == "LLLLFLLLLF"), 32'd1);
        l_req = 1'b0; f_req = 1'b0;
        cycle();

        // Pipelined fetches
        f_req = 1'b1;
        for (int a = 1; a <= 3; a++) begin
            f_addr = 32'(a);
            cycle();
        end
        f_req = 1'b0;
        repeat (2) cycle();

        // Out of range write and fetch
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'd256; l_wdata = 32'hCAFE_F00D;
        cycle();
        l_req = 1'b0; l_we = 1'b0;
        f_req = 1'b1; f_addr = 32'd300;
        cycle();
        f_req = 1'b0;
        cycle();

        // Write then read same address
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'd7; l_wdata = 32'hDEAD_BEEF;
        cycle();
        l_we = 1'b0;
        cycle();
        l_req = 1'b0;
        cycle();
        chk("wr_rd_model", ref_mem[7], 32'hDEAD_BEEF);

        // Random traffic honouring the hold-until-grant rule
        repeat (400) begin
            if (!f_req || last_f) begin
                f_req  = 1'($urandom_range(0, 1));
                f_addr = rand_addr();
            end
            if (!l_req || last_l) begin
                l_req   = 1'($urandom_range(0, 1));
                l_we    = 1'($urandom_range(0, 1));
                l_addr  = rand_addr();
                l_wdata = $urandom;
            end
            l_boot_done = ($urandom_range(0, 15) == 0);
            cycle();
        end
        l_req = 1'b0; l_we = 1'b0; l_boot_done = 1'b0; f_req = 1'b0;
        cycle();

        // Reset while a fetch read is in flight
        f_req = 1'b1; f_addr = 32'd5;
        @(negedge clk);
        chk("mid_rst_f_gnt", f_gnt, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_f_rvalid_a", f_rvalid, 1'b0);
        chk("mid_rst_cpu_hold", cpu_hold, 1'b1);
        chk("mid_rst_dbg_state", dbg_state, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_rst_f_rvalid_b", f_rvalid, 1'b0);
        model_reset();
        rst_n = 1'b1;
        cycle();

        // Boot release coinciding with a loader write
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'd5; l_wdata = 32'h1234_5678; l_boot_done = 1'b1;
        cycle();
        l_req = 1'b0; l_we = 1'b0; l_boot_done = 1'b0;
        cycle();
        f_req = 1'b0;
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
